// File: rtl/smi_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// smi_write_ctrl_if
// Bundles the IOC register bus, the SMI write-side pins and the two TX FIFO
// push ports of smi_write_ctrl. Clock and reset are kept as plain ports on
// the controller itself.
//   slave  : modport used by smi_write_ctrl
//   master : modport for whatever drives the controller (host logic / bench)
// Signals:
//   i_ioc[4:0], i_data_in[7:0], o_data_out[7:0], i_cs, i_fetch_cmd,
//   i_load_cmd                        IOC register access
//   i_smi_a[2:0], i_smi_swe_srw, i_smi_data_in[7:0], i_smi_test
//                                     SMI write side (RPi -> FPGA)
//   o_fifo_09_push, o_fifo_09_push_data[31:0], i_fifo_09_full
//   o_fifo_24_push, o_fifo_24_push_data[31:0], i_fifo_24_full
//                                     TX FIFO push ports
//   o_smi_write_req, o_overflow_error, o_address_error
//                                     flow control and sticky errors
// ---------------------------------------------------------------------------
interface smi_write_ctrl_if;
  logic [4:0]  i_ioc;
  logic [7:0]  i_data_in;
  logic [7:0]  o_data_out;
  logic        i_cs;
  logic        i_fetch_cmd;
  logic        i_load_cmd;
  logic [2:0]  i_smi_a;
  logic        i_smi_swe_srw;
  logic [7:0]  i_smi_data_in;
  logic        i_smi_test;
  logic        o_fifo_09_push;
  logic [31:0] o_fifo_09_push_data;
  logic        i_fifo_09_full;
  logic        o_fifo_24_push;
  logic [31:0] o_fifo_24_push_data;
  logic        i_fifo_24_full;
  logic        o_smi_write_req;
  logic        o_overflow_error;
  logic        o_address_error;

  modport slave (
    input  i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
    input  i_smi_a, i_smi_swe_srw, i_smi_data_in, i_smi_test,
    input  i_fifo_09_full, i_fifo_24_full,
    output o_data_out,
    output o_fifo_09_push, o_fifo_09_push_data,
    output o_fifo_24_push, o_fifo_24_push_data,
    output o_smi_write_req, o_overflow_error, o_address_error
  );

  modport master (
    output i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
    output i_smi_a, i_smi_swe_srw, i_smi_data_in, i_smi_test,
    output i_fifo_09_full, i_fifo_24_full,
    input  o_data_out,
    input  o_fifo_09_push, o_fifo_09_push_data,
    input  o_fifo_24_push, o_fifo_24_push_data,
    input  o_smi_write_req, o_overflow_error, o_address_error
  );
endinterface

// File: rtl/smi_write_ctrl.sv
// ---------------------------------------------------------------------------
// smi_write_ctrl
// SMI write-path controller (RPi -> FPGA). Synchronizes the SMI write strobe
// and data bus, packs four bytes MSB-first into a 32-bit word and pushes the
// word into the 0.9 GHz (SMI address 3'b001) or 2.4 GHz (3'b010) TX FIFO.
// Reports FIFO readiness to the RPi and exposes status / sticky errors on the
// IOC register bus.
//
// Ports:
//   i_sys_clk  : system clock (sole clock)
//   i_reset    : asynchronous, active-high reset
//   bus        : smi_write_ctrl_if.slave (IOC bus, SMI pins, FIFO ports)
//
// Parameters:
//   MODULE_VERSION : value read back at IOC index 5'b00000
//   SYNC_STAGES    : synchronizer depth for SWE and data, legal 2..3
//
// Optional build macro SMI_WRITE_TEST_EN: when defined and i_smi_test=1 the
// packer is bypassed, each byte is checked against a per-channel incrementing
// counter and mismatches are counted (IOC index 5'b00011). When undefined,
// i_smi_test is ignored and IOC 5'b00011 reads 0.
// ---------------------------------------------------------------------------
module smi_write_ctrl #(
  parameter logic [7:0] MODULE_VERSION = 8'h01,
  parameter int         SYNC_STAGES    = 2
) (
  input logic              i_sys_clk,
  input logic              i_reset,
  smi_write_ctrl_if.slave  bus
);

  localparam logic [2:0] ADDR_09 = 3'b001;
  localparam logic [2:0] ADDR_24 = 3'b010;
  localparam logic [4:0] IOC_VERSION = 5'b00000;
  localparam logic [4:0] IOC_STATUS  = 5'b00010;
  localparam logic [4:0] IOC_TEST    = 5'b00011;

  // -------------------------------------------------------------------------
  // Synchronizers: SWE and data move in lockstep, stage 0 is the newest.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] swe_sync_reg;
  logic [7:0]             data_sync_reg [SYNC_STAGES];

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      swe_sync_reg <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_reg[i] <= 8'h00;
    end else begin
      swe_sync_reg     <= {swe_sync_reg[SYNC_STAGES-2:0], bus.i_smi_swe_srw};
      data_sync_reg[0] <= bus.i_smi_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_reg[i] <= data_sync_reg[i-1];
    end
  end

  // Falling edge: the older of the last two stages is still high while the
  // newer one has gone low. The data byte taken is the one sampled together
  // with the first low SWE sample, i.e. while the RPi holds the bus stable.
  logic       strobe;
  logic [7:0] sync_byte;
  assign strobe    = swe_sync_reg[SYNC_STAGES-1] & ~swe_sync_reg[SYNC_STAGES-2];
  assign sync_byte = data_sync_reg[SYNC_STAGES-2];

  logic addr_legal;
  assign addr_legal = (bus.i_smi_a == ADDR_09) || (bus.i_smi_a == ADDR_24);

  // -------------------------------------------------------------------------
  // IOC decode
  // -------------------------------------------------------------------------
  logic ioc_rd;
  logic ioc_wr;
  logic clr_ovf;
  logic clr_addr;
  logic test_clr;
  assign ioc_rd   = bus.i_cs & bus.i_fetch_cmd;
  assign ioc_wr   = bus.i_cs & bus.i_load_cmd;
  assign clr_ovf  = ioc_wr && (bus.i_ioc == IOC_STATUS) && bus.i_data_in[0];
  assign clr_addr = ioc_wr && (bus.i_ioc == IOC_STATUS) && bus.i_data_in[1];
  assign test_clr = ioc_wr && (bus.i_ioc == IOC_TEST);

  // -------------------------------------------------------------------------
  // Optional test-pattern checker
  // -------------------------------------------------------------------------
  logic       test_active;
  logic [7:0] mismatch_cnt;

`ifdef SMI_WRITE_TEST_EN
  logic       test_strobe;
  logic [1:0] chan_mismatch;
  logic [7:0] mismatch_reg;

  assign test_active = bus.i_smi_test;
  assign test_strobe = strobe & test_active & addr_legal;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      localparam logic [2:0] CH_ADDR = (gi == 0) ? ADDR_09 : ADDR_24;
      logic [7:0] expect_reg;
      logic       chan_hit;

      assign chan_hit          = test_strobe && (bus.i_smi_a == CH_ADDR);
      assign chan_mismatch[gi] = chan_hit && (sync_byte != expect_reg);

      // Whether the byte matched or not, the next expected value is the
      // received byte + 1 (on a match that equals expect_reg + 1).
      always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
          expect_reg <= 8'h00;
        end else if (test_clr) begin
          expect_reg <= 8'h00;
        end else if (chan_hit) begin
          expect_reg <= sync_byte + 8'd1;
        end
      end
    end
  endgenerate

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      mismatch_reg <= 8'h00;
    end else if (test_clr) begin
      mismatch_reg <= 8'h00;
    end else if ((|chan_mismatch) && (mismatch_reg != 8'hFF)) begin
      mismatch_reg <= mismatch_reg + 8'd1;
    end
  end

  assign mismatch_cnt = mismatch_reg;
`else
  // Test mode not built: the select pin and the clear strobe have no effect.
  logic unused_test_pins;
  assign unused_test_pins = &{1'b0, bus.i_smi_test, test_clr};
  assign test_active      = 1'b0;
  assign mismatch_cnt     = 8'h00;
`endif

  // -------------------------------------------------------------------------
  // Byte packer
  // -------------------------------------------------------------------------
  logic [1:0]  cnt_reg,    cnt_next;
  logic [2:0]  addr_reg,   addr_next;
  logic [31:0] word_reg,   word_next;
  logic        push09_reg, push09_next;
  logic        push24_reg, push24_next;
  logic [31:0] data09_reg, data09_next;
  logic [31:0] data24_reg, data24_next;
  logic        ovf_reg,    ovf_next;
  logic        aerr_reg,   aerr_next;
  logic        req_reg,    req_next;
  logic [7:0]  dout_reg,   dout_next;
  logic        ovf_set;
  logic        aerr_set;
  logic [31:0] full_word;

  assign full_word = {word_reg[31:8], sync_byte};

  always_comb begin
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    word_next   = word_reg;
    push09_next = 1'b0;
    push24_next = 1'b0;
    data09_next = data09_reg;
    data24_next = data24_reg;
    ovf_set     = 1'b0;
    aerr_set    = 1'b0;

    if (strobe) begin
      if (!addr_legal) begin
        aerr_set = 1'b1;
        cnt_next = 2'd0;
      end else if (test_active) begin
        // Test bytes never reach the FIFOs; any partial word is abandoned.
        cnt_next = 2'd0;
      end else if ((cnt_reg == 2'd0) || (bus.i_smi_a != addr_reg)) begin
        // First byte of a word, or a channel switch that drops the partial.
        addr_next = bus.i_smi_a;
        word_next = {sync_byte, 24'h000000};
        cnt_next  = 2'd1;
      end else begin
        cnt_next = cnt_reg + 2'd1;
        case (cnt_reg)
          2'd1:    word_next[23:16] = sync_byte;
          2'd2:    word_next[15:8]  = sync_byte;
          default: word_next[7:0]   = sync_byte;
        endcase
        if (cnt_reg == 2'd3) begin
          if (addr_reg == ADDR_09) begin
            if (bus.i_fifo_09_full) begin
              ovf_set = 1'b1;
            end else begin
              push09_next = 1'b1;
              data09_next = full_word;
            end
          end else begin
            if (bus.i_fifo_24_full) begin
              ovf_set = 1'b1;
            end else begin
              push24_next = 1'b1;
              data24_next = full_word;
            end
          end
        end
      end
    end
  end

  // Sticky errors: a set in the same cycle as a clear wins.
  assign ovf_next  = ovf_set  | (ovf_reg  & ~clr_ovf);
  assign aerr_next = aerr_set | (aerr_reg & ~clr_addr);

  assign req_next = ((bus.i_smi_a == ADDR_09) && !bus.i_fifo_09_full) ||
                    ((bus.i_smi_a == ADDR_24) && !bus.i_fifo_24_full);

  always_comb begin
    dout_next = dout_reg;
    if (ioc_rd) begin
      case (bus.i_ioc)
        IOC_VERSION: dout_next = MODULE_VERSION;
        IOC_STATUS:  dout_next = {3'b000, bus.i_fifo_24_full, bus.i_fifo_09_full,
                                  aerr_reg, ovf_reg, 1'b0};
        IOC_TEST:    dout_next = mismatch_cnt;
        default:     dout_next = dout_reg;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_reg    <= 2'd0;
      addr_reg   <= 3'b000;
      word_reg   <= 32'h0;
      push09_reg <= 1'b0;
      push24_reg <= 1'b0;
      data09_reg <= 32'h0;
      data24_reg <= 32'h0;
      ovf_reg    <= 1'b0;
      aerr_reg   <= 1'b0;
      req_reg    <= 1'b0;
      dout_reg   <= 8'h00;
    end else begin
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      word_reg   <= word_next;
      push09_reg <= push09_next;
      push24_reg <= push24_next;
      data09_reg <= data09_next;
      data24_reg <= data24_next;
      ovf_reg    <= ovf_next;
      aerr_reg   <= aerr_next;
      req_reg    <= req_next;
      dout_reg   <= dout_next;
    end
  end

  assign bus.o_fifo_09_push      = push09_reg;
  assign bus.o_fifo_09_push_data = data09_reg;
  assign bus.o_fifo_24_push      = push24_reg;
  assign bus.o_fifo_24_push_data = data24_reg;
  assign bus.o_overflow_error    = ovf_reg;
  assign bus.o_address_error     = aerr_reg;
  assign bus.o_smi_write_req     = req_reg;
  assign bus.o_data_out          = dout_reg;

endmodule

// File: tb/tb_smi_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_smi_write_ctrl
// Scoreboard bench for smi_write_ctrl: stimulus tasks update a byte-queue
// reference model and push expected FIFO words; an independent monitor pops
// and compares on every push it observes.
// ---------------------------------------------------------------------------
module tb_smi_write_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  smi_write_ctrl_if bus ();

  smi_write_ctrl #(
    .MODULE_VERSION (8'h01),
    .SYNC_STAGES    (2)
  ) dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        ch24;
    logic [31:0] word;
  } push_t;

  push_t      exp_q[$];
  logic [7:0] part_q[$];
  logic [2:0] part_ch = 3'b000;
  logic       m_ovf = 1'b0;
  logic       m_aerr = 1'b0;
  logic [31:0] last09 = 32'h0;
  logic [31:0] last24 = 32'h0;
  bit         test_on = 1'b0;
  logic [7:0] m_exp [2];
  int         m_mism = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: any push must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && (bus.o_fifo_09_push || bus.o_fifo_24_push)) begin
      push_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got push09=%b push24=%b expected none at %0t",
                 bus.o_fifo_09_push, bus.o_fifo_24_push, $time);
      end else begin
        e = exp_q.pop_front();
        check("push_single", {31'b0, bus.o_fifo_09_push & bus.o_fifo_24_push}, 32'd0);
        check("push_chan24", {31'b0, bus.o_fifo_24_push}, {31'b0, e.ch24});
        check("push_data", e.ch24 ? bus.o_fifo_24_push_data : bus.o_fifo_09_push_data, e.word);
      end
    end
  end

  // Reference model: one SMI byte, applied when the byte is issued.
  task automatic model_byte(input logic [2:0] a, input logic [7:0] b);
    logic [31:0] w;
    logic        full;
    if (a != 3'b001 && a != 3'b010) begin
      m_aerr = 1'b1;
      part_q.delete();
    end else if (test_on) begin
      part_q.delete();
      if (b != m_exp[a == 3'b010]) m_mism = (m_mism < 255) ? m_mism + 1 : 255;
      m_exp[a == 3'b010] = b + 8'd1;
    end else begin
      if (part_q.size() == 0 || a != part_ch) begin
        part_q.delete();
        part_ch = a;
      end
      part_q.push_back(b);
      if (part_q.size() == 4) begin
        w = {part_q[0], part_q[1], part_q[2], part_q[3]};
        full = (a == 3'b001) ? bus.i_fifo_09_full : bus.i_fifo_24_full;
        if (full) begin
          m_ovf = 1'b1;
        end else begin
          exp_q.push_back('{ch24: (a == 3'b010), word: w});
          if (a == 3'b001) last09 = w; else last24 = w;
        end
        part_q.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [2:0] a, input logic [7:0] b);
    model_byte(a, b);
    bus.i_smi_a       = a;
    bus.i_smi_data_in = b;
    @(posedge clk); #1;
    bus.i_smi_swe_srw = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.i_smi_swe_srw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic ioc_write(input logic [4:0] idx, input logic [7:0] d);
    bus.i_cs = 1'b1; bus.i_load_cmd = 1'b1; bus.i_ioc = idx; bus.i_data_in = d;
    @(posedge clk); #1;
    bus.i_cs = 1'b0; bus.i_load_cmd = 1'b0;
    if (idx == 5'b00010) begin
      if (d[0]) m_ovf = 1'b0;
      if (d[1]) m_aerr = 1'b0;
    end
    if (idx == 5'b00011) begin
      m_mism = 0; m_exp[0] = 8'h00; m_exp[1] = 8'h00;
    end
  endtask

  task automatic ioc_read(input logic [4:0] idx, output logic [7:0] d);
    bus.i_cs = 1'b1; bus.i_fetch_cmd = 1'b1; bus.i_ioc = idx;
    @(posedge clk); #1;
    bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0;
    d = bus.o_data_out;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_pending", exp_q.size(), 32'd0);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_ovf"}, {31'b0, bus.o_overflow_error}, {31'b0, m_ovf});
    check({tag, "_aerr"}, {31'b0, bus.o_address_error}, {31'b0, m_aerr});
  endtask

  task automatic check_req();
    logic r;
    repeat (2) @(posedge clk);
    #1;
    r = (bus.i_smi_a == 3'b001 && !bus.i_fifo_09_full) ||
        (bus.i_smi_a == 3'b010 && !bus.i_fifo_24_full);
    check("write_req", {31'b0, bus.o_smi_write_req}, {31'b0, r});
  endtask

  task automatic check_status();
    logic [7:0] d;
    ioc_read(5'b00010, d);
    check("status", d, {3'b000, bus.i_fifo_24_full, bus.i_fifo_09_full, m_aerr, m_ovf, 1'b0});
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] a;
    int r;
    m_exp[0] = 8'h00; m_exp[1] = 8'h00;
    bus.i_ioc = 5'd0; bus.i_data_in = 8'h00; bus.i_cs = 1'b0;
    bus.i_fetch_cmd = 1'b0; bus.i_load_cmd = 1'b0;
    bus.i_smi_a = 3'b000; bus.i_smi_swe_srw = 1'b1; bus.i_smi_data_in = 8'h00;
    bus.i_smi_test = 1'b0; bus.i_fifo_09_full = 1'b0; bus.i_fifo_24_full = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_push09", {31'b0, bus.o_fifo_09_push}, 32'd0);
    check("rst_data09", bus.o_fifo_09_push_data, 32'd0);
    check("rst_req", {31'b0, bus.o_smi_write_req}, 32'd0);
    check("rst_dout", {24'b0, bus.o_data_out}, 32'd0);
    check_errs("rst");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Basic 0.9 GHz word
    bus.i_smi_a = 3'b001;
    check_req();
    send_byte(3'b001, 8'hAA); send_byte(3'b001, 8'hBB);
    send_byte(3'b001, 8'hCC); send_byte(3'b001, 8'hDD);
    drain();
    check("hold_data09", bus.o_fifo_09_push_data, 32'hAABBCCDD);
    check("hold_data24", bus.o_fifo_24_push_data, last24);

    // Full 2.4 GHz FIFO drops the word
    bus.i_fifo_24_full = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(3'b010, 8'h10 + 8'(i));
    drain();
    check_errs("full");
    check_req();
    ioc_write(5'b00010, 8'h01);
    @(posedge clk); #1;
    check_errs("ovf_clr");
    bus.i_fifo_24_full = 1'b0;

    // Channel switch mid-word
    send_byte(3'b001, 8'h11); send_byte(3'b001, 8'h22);
    send_byte(3'b010, 8'h33); send_byte(3'b010, 8'h44);
    send_byte(3'b010, 8'h55); send_byte(3'b010, 8'h66);
    drain();

    // Illegal address
    send_byte(3'b000, 8'h77);
    drain();
    check_errs("illegal");
    check_status();
    ioc_read(5'b00000, d);
    check("version", {24'b0, d}, 32'h01);
    ioc_write(5'b00010, 8'h02);
    @(posedge clk); #1;
    check_errs("aerr_clr");

    // Reset mid-word discards the partial
    send_byte(3'b001, 8'hE1); send_byte(3'b001, 8'hE2);
    @(negedge clk) rst = 1'b1;
    #1;
    check("arst_data09", bus.o_fifo_09_push_data, 32'd0);
    check("arst_req", {31'b0, bus.o_smi_write_req}, 32'd0);
    part_q.delete(); m_ovf = 1'b0; m_aerr = 1'b0; last09 = 32'h0; last24 = 32'h0;
    m_exp[0] = 8'h00; m_exp[1] = 8'h00; m_mism = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) send_byte(3'b001, 8'(i));
    drain();

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) a = 3'b001;
      else if (r < 8) a = 3'b010;
      else if (r == 8) a = 3'b000;
      else a = 3'($urandom_range(3, 7));
      bus.i_fifo_09_full = ($urandom_range(0, 7) == 0);
      bus.i_fifo_24_full = ($urandom_range(0, 7) == 0);
      send_byte(a, 8'($urandom));
      if (i % 16 == 15) begin
        drain();
        check_errs("rand");
        check_status();
        check_req();
        ioc_write(5'b00010, 8'($urandom_range(0, 3)));
        @(posedge clk); #1;
        check_errs("rand_clr");
      end
    end
    drain();
    check("rand_last09", bus.o_fifo_09_push_data, last09);
    check("rand_last24", bus.o_fifo_24_push_data, last24);
    bus.i_fifo_09_full = 1'b0;
    bus.i_fifo_24_full = 1'b0;

`ifdef SMI_WRITE_TEST_EN
    ioc_write(5'b00011, 8'h00);
    bus.i_smi_test = 1'b1;
    test_on = 1'b1;
    send_byte(3'b001, 8'h00); send_byte(3'b001, 8'h01); send_byte(3'b001, 8'h02);
    send_byte(3'b001, 8'h05); send_byte(3'b001, 8'h06);
    drain();
    ioc_read(5'b00011, d);
    check("test_mismatch", {24'b0, d}, m_mism);
    check("test_mismatch_one", {24'b0, d}, 32'd1);
    bus.i_smi_test = 1'b0;
    test_on = 1'b0;
`else
    ioc_read(5'b00011, d);
    check("test_reg_zero", {24'b0, d}, 32'd0);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("final_queue", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a stimulus task never returns.
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish before 2ms");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/smi_write_ctrl.md
Name: smi_write_ctrl

Overview:
- SMI write-path controller: RPi → FPGA sample path, the counterpart of the SMI read-path sender.
- Receives 8-bit SMI write strobes from the RPi and packs 4 bytes MSB-first into 32-bit words.
- Pushes each completed word into the 0.9 GHz or 2.4 GHz TX FIFO, selected by SMI address.
- Reports FIFO readiness to the RPi and exposes status and sticky errors over the IOC register interface.

Parameters:
- MODULE_VERSION, 8'h01, value returned on IOC 5'b00000.
- SYNC_STAGES, 2, synchronizer depth for SWE and data; legal values 2..3.

Ports:
- i_sys_clk  in  1  FPGA system clock; sole clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_ioc  in  5  IOC register index.
- i_data_in  in  8  IOC write data.
- o_data_out  out  8  IOC read data.
- i_cs  in  1  IOC chip select.
- i_fetch_cmd  in  1  IOC read strobe.
- i_load_cmd  in  1  IOC write strobe.
- i_smi_a  in  3  SMI address; 3'b001 selects write 0.9 GHz, 3'b010 selects write 2.4 GHz.
- i_smi_swe_srw  in  1  SMI write strobe, active low.
- i_smi_data_in  in  8  SMI data bus (RPi → FPGA).
- i_smi_test  in  1  test-pattern mode select.
- o_fifo_09_push  out  1  1-cycle push strobe to the 0.9 GHz TX FIFO.
- o_fifo_09_push_data  out  32  word for the 0.9 GHz TX FIFO.
- i_fifo_09_full  in  1  0.9 GHz TX FIFO full.
- o_fifo_24_push  out  1  1-cycle push strobe to the 2.4 GHz TX FIFO.
- o_fifo_24_push_data  out  32  word for the 2.4 GHz TX FIFO.
- i_fifo_24_full  in  1  2.4 GHz TX FIFO full.
- o_smi_write_req  out  1  registered; high when the addressed write FIFO is not full.
- o_overflow_error  out  1  sticky: a word was dropped because its FIFO was full.
- o_address_error  out  1  sticky: a strobe arrived at a non-write address.

Behaviour:
- Reset values: all outputs 0; byte counter 0; captured-address register 3'b000; synchronizer registers at 1 (SWE) and 0 (data).
- Reset is asynchronous; asserting it mid-word discards the partial word.
- Synchronization: SWE and the data bus pass through SYNC_STAGES flops in lockstep.
- Strobe detection: a strobe is a falling edge on the last two SWE stages (previous stage = 1, current stage = 0). On the strobe cycle, the synchronized data byte is captured.
- RPi timing contract: SWE low ≥ 2 clocks and high ≥ 2 clocks; data stable while SWE is low.
- Packing, MSB-first:
  - byte 0 → [31:24], byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0].
  - Counter is 2 bits and wraps 3 → 0 on the 4th byte.
- Push: on the 4th byte, push data and the push strobe are registered, so push is high for exactly 1 clock, the clock after the 4th strobe cycle.
  - Only the FIFO matching the captured address pushes.
  - Push data holds until the next push.
- Full FIFO: if the target FIFO's full flag is high on the 4th-byte cycle, no push occurs, the word is dropped, o_overflow_error is set and the counter still wraps to 0.
- Address handling:
  - The address is captured on byte 0.
  - If a later strobe sees a different write address, the partial word is discarded and that byte becomes byte 0 of the new channel.
- Illegal address: a strobe with i_smi_a not equal to 001 or 010 sets o_address_error, the byte is ignored and the counter resets to 0.
- o_smi_write_req: registered each clock as (addr==001 & !fifo_09_full) | (addr==010 & !fifo_24_full).
- IOC reads (i_cs & i_fetch_cmd), registered in 1 clock:
  - 5'b00000: MODULE_VERSION.
  - 5'b00010: {3'b0, fifo_24_full, fifo_09_full, address_error, overflow_error, 1'b0}.
  - 5'b00011: test mismatch count.
  - Other indices: o_data_out holds its value.
- IOC write: i_cs & i_load_cmd with i_ioc=5'b00010. i_data_in[0]=1 clears overflow; i_data_in[1]=1 clears address error.
- Simultaneous error set and clear in the same cycle: set wins.

Optional Feature:
- Macro: SMI_WRITE_TEST_EN.
- Defined, with i_smi_test=1:
  - No FIFO pushes occur.
  - Each byte is compared with a per-channel 8-bit incrementing expected counter (reset 0; increments per byte and wraps 255 → 0).
  - On mismatch, the 8-bit mismatch count increments, saturating at 255, and the expected counter resyncs to received byte + 1.
  - IOC write to 5'b00011 clears the mismatch count and both expected counters.
- Not defined: i_smi_test is ignored, IOC 5'b00011 reads 0 and the normal path runs.

Test Plan:
- Reset release; at addr 001 write AA,BB,CC,DD → one o_fifo_09_push with data 32'hAABBCCDD, 1 clock after the 4th strobe cycle; o_fifo_24_push stays 0.
- Addr 010, fifo_24_full=1, write 4 bytes → no push, o_overflow_error=1; IOC write 00010 with data 01 → o_overflow_error=0.
- Addr 001 write 11,22, switch to 010, write 33,44,55,66 → no 0.9 GHz push; single 2.4 GHz push of 32'h33445566.
- Addr 000, one strobe → o_address_error=1 and no push; IOC read 00010 → bit 2 = 1.
- Assert reset after 2 bytes, release, write 4 bytes 01..04 → push of 32'h01020304.
- SMI_WRITE_TEST_EN defined, test=1: send 00,01,02,05,06 → IOC read 00011 returns 1; no pushes.
